// File: rtl/vga_pkg.sv
// Shared types, 800x600 defaults and colour helpers for the VGA test-pattern path.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_BORDER,
    MODE_BARS,
    MODE_CHECKER,
    MODE_BOX
  } mode_t;

  localparam int H_ACTIVE_DEF = 800;
  localparam int V_ACTIVE_DEF = 600;
  localparam int CW_DEF       = 4;
  localparam int BOX_W_DEF    = 64;
  localparam int BOX_H_DEF    = 48;
  localparam int STEP_DEF     = 2;
  localparam int CHK_LOG2_DEF = 5;

  // Channel levels are kept symbolic until the output register so the
  // colour logic stays independent of the channel width.
  typedef enum logic [1:0] {
    LVL_ZERO,
    LVL_MID,
    LVL_FULL
  } level_t;

  typedef struct packed {
    level_t r;
    level_t g;
    level_t b;
  } rgb_t;

  localparam rgb_t C_BLACK   = '{r: LVL_ZERO, g: LVL_ZERO, b: LVL_ZERO};
  localparam rgb_t C_WHITE   = '{r: LVL_FULL, g: LVL_FULL, b: LVL_FULL};
  localparam rgb_t C_GREY    = '{r: LVL_MID,  g: LVL_MID,  b: LVL_MID};
  localparam rgb_t C_YELLOW  = '{r: LVL_FULL, g: LVL_FULL, b: LVL_ZERO};
  localparam rgb_t C_CYAN    = '{r: LVL_ZERO, g: LVL_FULL, b: LVL_FULL};
  localparam rgb_t C_GREEN   = '{r: LVL_ZERO, g: LVL_FULL, b: LVL_ZERO};
  localparam rgb_t C_MAGENTA = '{r: LVL_FULL, g: LVL_ZERO, b: LVL_FULL};
  localparam rgb_t C_RED     = '{r: LVL_FULL, g: LVL_ZERO, b: LVL_ZERO};
  localparam rgb_t C_BLUE    = '{r: LVL_ZERO, g: LVL_ZERO, b: LVL_FULL};

  function automatic rgb_t bar_colour(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = C_WHITE;
      3'd1:    c = C_YELLOW;
      3'd2:    c = C_CYAN;
      3'd3:    c = C_GREEN;
      3'd4:    c = C_MAGENTA;
      3'd5:    c = C_RED;
      3'd6:    c = C_BLUE;
      default: c = C_BLACK;
    endcase
    return c;
  endfunction

  function automatic rgb_t border_colour(input logic top, input logic bot,
                                         input logic left, input logic right,
                                         input rgb_t fill);
    rgb_t c;
    if (top)        c = C_YELLOW;
    else if (bot)   c = C_RED;
    else if (left)  c = C_GREEN;
    else if (right) c = C_BLUE;
    else            c = fill;
    return c;
  endfunction

  // One bounce step on one axis; result is {dir_next, pos_next}.
  function automatic logic [12:0] bounce_step(input logic [11:0] pos, input logic dir,
                                              input logic [11:0] lim, input logic [11:0] step);
    logic [12:0] res;
    if (dir) begin
      if (pos + step > lim) res = {1'b0, lim};
      else                  res = {1'b1, pos + step};
    end else begin
      if (pos < step) res = {1'b1, 12'd0};
      else            res = {1'b0, pos - step};
    end
    return res;
  endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position: advances one step per axis on every frame tick and
// reverses at the edges of the active area.
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int BOX_W    = BOX_W_DEF,
  parameter int BOX_H    = BOX_H_DEF,
  parameter int STEP     = STEP_DEF
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        frame_tick,
  output logic [11:0] box_x,
  output logic [11:0] box_y
);

  localparam logic [11:0] X_LIM = 12'(H_ACTIVE - BOX_W);
  localparam logic [11:0] Y_LIM = 12'(V_ACTIVE - BOX_H);
  localparam logic [11:0] STP   = 12'(STEP);

  logic        dir_x, dir_y;
  logic [12:0] nx, ny;

  assign nx = bounce_step(box_x, dir_x, X_LIM, STP);
  assign ny = bounce_step(box_y, dir_y, Y_LIM, STP);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      box_x <= '0;
      box_y <= '0;
      dir_x <= 1'b1;
      dir_y <= 1'b1;
    end else if (frame_tick) begin
      {dir_x, box_x} <= nx;
      {dir_y, box_y} <= ny;
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// Pipelined VGA test-pattern generator: stage 1 registers timing and region
// flags, stage 2 selects the colour for the frame-latched mode.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int CW       = CW_DEF,
  parameter int BOX_W    = BOX_W_DEF,
  parameter int BOX_H    = BOX_H_DEF,
  parameter int STEP     = STEP_DEF,
  parameter int CHK_LOG2 = CHK_LOG2_DEF
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic [1:0]    mode_in,
  input  logic [10:0]   hcount,
  input  logic [10:0]   vcount,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          hblnk,
  input  logic          vblnk,
  output logic          hs,
  output logic          vs,
  output logic          hblnk_out,
  output logic          vblnk_out,
  output logic [CW-1:0] r,
  output logic [CW-1:0] g,
  output logic [CW-1:0] b,
  output logic          frame_tick
);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam logic [CW-1:0] MID = {1'b1, {(CW-1){1'b0}}};

  logic [11:0] h12, v12, box_x, box_y;
  logic [2:0]  bar_idx;
  logic        in_box;

  logic        hs1, vs1, hb1, vb1, vb_hist;
  logic        top1, bot1, left1, right1, chk1, box1;
  logic [2:0]  bar1;
  mode_t       mode_q;
  rgb_t        pix;

  assign h12 = {1'b0, hcount};
  assign v12 = {1'b0, vcount};

  // Rising edge of the stage-1 vblank copy marks the frame boundary.
  assign frame_tick = vb1 & ~vb_hist;

  vga_box_mover #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .BOX_W    (BOX_W),
    .BOX_H    (BOX_H),
    .STEP     (STEP)
  ) u_box (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .box_x      (box_x),
    .box_y      (box_y)
  );

  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (h12 >= 12'(k * BAR_W)) bar_idx = 3'(k);
    end
  end

  assign in_box = (h12 >= box_x) && (h12 < box_x + 12'(BOX_W)) &&
                  (v12 >= box_y) && (v12 < box_y + 12'(BOX_H));

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hs1     <= 1'b0;
      vs1     <= 1'b0;
      hb1     <= 1'b0;
      vb1     <= 1'b0;
      vb_hist <= 1'b1;
      top1    <= 1'b0;
      bot1    <= 1'b0;
      left1   <= 1'b0;
      right1  <= 1'b0;
      bar1    <= 3'd0;
      chk1    <= 1'b0;
      box1    <= 1'b0;
    end else begin
      hs1     <= hsync;
      vs1     <= vsync;
      hb1     <= hblnk;
      vb1     <= vblnk;
      vb_hist <= vb1;
      top1    <= (v12 == 12'd0);
      bot1    <= (v12 == 12'(V_ACTIVE - 1));
      left1   <= (h12 == 12'd0);
      right1  <= (h12 == 12'(H_ACTIVE - 1));
      bar1    <= bar_idx;
      chk1    <= hcount[CHK_LOG2] ^ vcount[CHK_LOG2];
      box1    <= in_box;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n)          mode_q <= MODE_BORDER;
    else if (frame_tick) mode_q <= mode_t'(mode_in);
  end

  always_comb begin
    pix = C_BLACK;
    if (!(hb1 || vb1)) begin
      case (mode_q)
        MODE_BORDER:  pix = border_colour(top1, bot1, left1, right1, C_GREY);
        MODE_BARS:    pix = bar_colour(bar1);
        MODE_CHECKER: pix = chk1 ? C_WHITE : C_BLACK;
        MODE_BOX:     pix = border_colour(top1, bot1, left1, right1,
                                          box1 ? C_YELLOW : C_BLACK);
        default:      pix = C_BLACK;
      endcase
    end
  end

  function automatic logic [CW-1:0] lvl(input level_t l);
    logic [CW-1:0] v;
    case (l)
      LVL_FULL: v = '1;
      LVL_MID:  v = MID;
      default:  v = '0;
    endcase
    return v;
  endfunction

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hs        <= 1'b0;
      vs        <= 1'b0;
      hblnk_out <= 1'b0;
      vblnk_out <= 1'b0;
      r         <= '0;
      g         <= '0;
      b         <= '0;
    end else begin
      hs        <= hs1;
      vs        <= vs1;
      hblnk_out <= hb1;
      vblnk_out <= vb1;
      r         <= lvl(pix.r);
      g         <= lvl(pix.g);
      b         <= lvl(pix.b);
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen: directed pattern checks, a long
// bouncing-box run and a random timing stream against a frame-level model.
module tb_vga_pattern_gen;

  localparam int H_ACT = 800;
  localparam int V_ACT = 600;
  localparam int BW    = 64;
  localparam int BH    = 48;
  localparam int STP   = 2;
  localparam int CHK   = 5;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  mode_in = 2'd0;
  logic [10:0] hcount = '0, vcount = '0;
  logic        hsync = 1'b0, vsync = 1'b0, hblnk = 1'b1, vblnk = 1'b0;
  logic        hs, vs, hblnk_out, vblnk_out, frame_tick;
  logic [3:0]  r, g, b;

  int errors = 0;
  int checks = 0;
  string tag = "init";

  int m_mode, m_bx, m_by, m_dx, m_dy;
  bit m_pending, m_vb_prev, exp_valid;
  logic [15:0] exp_prev;

  logic [11:0] bar_tab [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                               12'hF0F, 12'hF00, 12'h00F, 12'h000};

  always #5 pclk = ~pclk;

  vga_pattern_gen dut (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .mode_in    (mode_in),
    .hcount     (hcount),
    .vcount     (vcount),
    .hsync      (hsync),
    .vsync      (vsync),
    .hblnk      (hblnk),
    .vblnk      (vblnk),
    .hs         (hs),
    .vs         (vs),
    .hblnk_out  (hblnk_out),
    .vblnk_out  (vblnk_out),
    .r          (r),
    .g          (g),
    .b          (b),
    .frame_tick (frame_tick)
  );

  // Expected {r,g,b} for one pixel, straight from the pattern rules.
  function automatic logic [11:0] colour(int mode, int h, int v, bit blank, int bx, int by);
    int bar;
    if (blank) return 12'h000;
    if (mode == 0 || mode == 3) begin
      if (v == 0)         return 12'hFF0;
      if (v == V_ACT - 1) return 12'hF00;
      if (h == 0)         return 12'h0F0;
      if (h == H_ACT - 1) return 12'h00F;
      if (mode == 0)      return 12'h888;
      if (h >= bx && h < bx + BW && v >= by && v < by + BH) return 12'hFF0;
      return 12'h000;
    end
    if (mode == 1) begin
      bar = h / (H_ACT / 8);
      if (bar > 7) bar = 7;
      return bar_tab[bar];
    end
    return ((((h >> CHK) ^ (v >> CHK)) & 1) != 0) ? 12'hFFF : 12'h000;
  endfunction

  task automatic move_axis(inout int pos, inout int dir, input int lim);
    if (dir == 1) begin
      if (pos + STP > lim) begin pos = lim; dir = 0; end
      else pos = pos + STP;
    end else begin
      if (pos < STP) begin pos = 0; dir = 1; end
      else pos = pos - STP;
    end
  endtask

  function automatic int clampi(int x, int lo, int hi);
    return (x < lo) ? lo : ((x > hi) ? hi : x);
  endfunction

  // One pixel clock: drive inputs, advance the model, check the outputs
  // belonging to the previous pixel and the frame tick of this one.
  task automatic cycle(input int h, input int v, input bit hsn, input bit vsn,
                       input bit hb, input bit vb, input int md);
    logic [15:0] cur;
    int eff_mode;
    bit tick_exp;
    @(negedge pclk);
    hcount = 11'(h); vcount = 11'(v);
    hsync = hsn; vsync = vsn; hblnk = hb; vblnk = vb;
    mode_in = 2'(md);
    eff_mode = m_pending ? md : m_mode;
    cur = {hsn, vsn, hb, vb, colour(eff_mode, h, v, hb || vb, m_bx, m_by)};
    if (m_pending) begin
      move_axis(m_bx, m_dx, H_ACT - BW);
      move_axis(m_by, m_dy, V_ACT - BH);
      m_mode = md;
    end
    tick_exp = vb && !m_vb_prev;
    m_pending = tick_exp;
    m_vb_prev = vb;
    @(posedge pclk);
    #1;
    if (exp_valid) begin
      checks++;
      assert ({hs, vs, hblnk_out, vblnk_out, r, g, b} === exp_prev) else begin
        errors++;
        $error("FAIL %s_pixel observed=%h expected=%h", tag,
               {hs, vs, hblnk_out, vblnk_out, r, g, b}, exp_prev);
      end
    end
    checks++;
    assert (frame_tick === tick_exp) else begin
      errors++;
      $error("FAIL %s_tick observed=%b expected=%b", tag, frame_tick, tick_exp);
    end
    exp_prev = cur;
    exp_valid = 1'b1;
  endtask

  task automatic expect_rgb(input string name, input logic [11:0] want);
    checks++;
    assert ({r, g, b} === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, {r, g, b}, want);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    assert ({hs, vs, hblnk_out, vblnk_out, r, g, b, frame_tick} === 17'd0) else begin
      errors++;
      $error("FAIL reset_outputs observed=%h expected=0",
             {hs, vs, hblnk_out, vblnk_out, r, g, b, frame_tick});
    end
    m_mode = 0; m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
    m_pending = 1'b0; m_vb_prev = 1'b0; exp_valid = 1'b0;
    @(negedge pclk);
    hcount = '0; vcount = '0; hsync = 1'b0; vsync = 1'b0;
    hblnk = 1'b1; vblnk = 1'b0; mode_in = 2'd0;
    @(negedge pclk);
    rst_n = 1'b1;
  endtask

  task automatic vblank(input int md);
    repeat (3) cycle(0, V_ACT, 1'b0, 1'b1, 1'b1, 1'b1, md);
    cycle(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, md);
  endtask

  task automatic show(input int h, input int v, input int md);
    cycle(h, v, 1'b0, 1'b0, 1'b0, 1'b0, md);
    cycle(h, v, 1'b0, 1'b0, 1'b0, 1'b0, md);
  endtask

  task automatic box_frame();
    int hx [7];
    int vy [7];
    hx[0] = m_bx;           vy[0] = m_by;
    hx[1] = m_bx + BW - 1;  vy[1] = m_by + BH - 1;
    hx[2] = m_bx - 1;       vy[2] = m_by + 10;
    hx[3] = m_bx + BW;      vy[3] = m_by + 10;
    hx[4] = m_bx + 10;      vy[4] = m_by - 1;
    hx[5] = m_bx + 10;      vy[5] = m_by + BH;
    hx[6] = int'($urandom_range(0, H_ACT - 1));
    vy[6] = int'($urandom_range(0, V_ACT - 1));
    for (int i = 0; i < 7; i++)
      cycle(clampi(hx[i], 0, H_ACT - 1), clampi(vy[i], 0, V_ACT - 1),
            1'b0, 1'b0, 1'b0, 1'b0, 3);
    vblank(3);
  endtask

  initial begin
    #2;
    tag = "reset";
    do_reset();

    tag = "grey";
    show(5, 5, 0);
    expect_rgb("reset_grey", 12'h888);

    tag = "border";
    show(0, 300, 0);
    expect_rgb("border_green", 12'h0F0);
    show(799, 300, 0);
    expect_rgb("border_blue", 12'h00F);
    show(300, 599, 0);
    expect_rgb("border_red", 12'hF00);
    show(300, 0, 0);
    expect_rgb("border_yellow", 12'hFF0);
    cycle(300, 300, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    cycle(300, 300, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    expect_rgb("border_blank", 12'h000);

    tag = "latch";
    show(400, 300, 1);
    expect_rgb("latch_hold_mode0", 12'h888);
    vblank(1);
    show(100, 10, 1);
    expect_rgb("bar_yellow", 12'hFF0);
    show(750, 10, 1);
    expect_rgb("bar_black", 12'h000);
    show(250, 10, 2);
    expect_rgb("bar_cyan_hold", 12'h0FF);

    tag = "checker";
    vblank(2);
    show(32, 0, 2);
    expect_rgb("checker_white", 12'hFFF);
    show(32, 32, 2);
    expect_rgb("checker_black", 12'h000);

    tag = "bounce";
    vblank(3);
    for (int f = 0; f < 400; f++) box_frame();

    tag = "random";
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
      end
      cycle(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
            1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
            int'($urandom_range(0, 3)));
    end
    cycle(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
